// File: rtl/avalon_st_gen_pkg.sv
// Shared types and address map for the Avalon-ST generator burst sequencer.
package avalon_st_gen_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_SAMP,
        S_WR_START,
        S_SETTLE,
        S_POLL_RD,
        S_POLL_CHK,
        S_POLL_WAIT,
        S_GAP,
        S_FINISH
    } seq_state_t;

    localparam logic [3:0] GEN_ADDR_STATE   = 4'd4;
    localparam logic [3:0] GEN_ADDR_START   = 4'd5;
    localparam logic [3:0] GEN_ADDR_SAMPLES = 4'd8;

    localparam logic [3:0] CSR_ID          = 4'd0;
    localparam logic [3:0] CSR_VERSION     = 4'd1;
    localparam logic [3:0] CSR_ZERO        = 4'd2;
    localparam logic [3:0] CSR_SCRATCH     = 4'd3;
    localparam logic [3:0] CSR_STATUS      = 4'd4;
    localparam logic [3:0] CSR_CTRL        = 4'd5;
    localparam logic [3:0] CSR_NUM_BURSTS  = 4'd6;
    localparam logic [3:0] CSR_SAMPLES     = 4'd7;
    localparam logic [3:0] CSR_GAP         = 4'd8;
    localparam logic [3:0] CSR_BURSTS_DONE = 4'd9;

    localparam logic [31:0] SEQ_ID       = 32'h5E9C0001;
    localparam logic [31:0] SEQ_VERSION  = 32'h00000100;
    localparam logic [31:0] CSR_UNMAPPED = 32'hdeadbeef;

    function automatic logic [31:0] status_word(input logic err, input logic done,
                                                input logic busy);
        return {29'd0, err, done, busy};
    endfunction

endpackage

// File: rtl/avalon_st_gen_sequencer.sv
// Burst scheduler: programs the pattern generator over Avalon-MM, polls it to
// completion, waits a gap and repeats for the requested number of bursts.
module avalon_st_gen_sequencer
    import avalon_st_gen_pkg::*;
#(
    parameter int POLL_INTERVAL = 16,
    parameter int SETTLE_CYC    = 3
) (
    input  logic        csi_clk_clk,
    input  logic        rsi_reset_reset,
    input  logic [3:0]  avs_ctrl_address,
    input  logic        avs_ctrl_read,
    input  logic        avs_ctrl_write,
    output logic [31:0] avs_ctrl_readdata,
    input  logic [31:0] avs_ctrl_writedata,
    output logic [3:0]  avm_gen_address,
    output logic        avm_gen_read,
    output logic        avm_gen_write,
    output logic [31:0] avm_gen_writedata,
    input  logic [31:0] avm_gen_readdata,
    output logic        ins_irq_irq
);

    seq_state_t  state;
    logic        busy, done, err, abort_pend;
    logic [31:0] bursts_done, cnt;
    logic [31:0] scratch, cfg_bursts, cfg_samples, cfg_gap;
    logic [31:0] bursts_shadow, samples_shadow, gap_shadow;
    logic [31:0] rd_mux;
    logic        ctrl_wr, start_req, abort_req, status_clr;
    logic        unused_readdata;

    assign unused_readdata = ^avm_gen_readdata[31:1];

    // Abort beats start when both bits are written together.
    assign ctrl_wr    = avs_ctrl_write && (avs_ctrl_address == CSR_CTRL);
    assign start_req  = ctrl_wr && avs_ctrl_writedata[0] && !avs_ctrl_writedata[1];
    assign abort_req  = ctrl_wr && avs_ctrl_writedata[1];
    assign status_clr = avs_ctrl_write && (avs_ctrl_address == CSR_STATUS);

    always_comb begin
        rd_mux = CSR_UNMAPPED;
        case (avs_ctrl_address)
            CSR_ID:          rd_mux = SEQ_ID;
            CSR_VERSION:     rd_mux = SEQ_VERSION;
            CSR_ZERO:        rd_mux = 32'd0;
            CSR_SCRATCH:     rd_mux = scratch;
            CSR_STATUS:      rd_mux = status_word(err, done, busy);
            CSR_CTRL:        rd_mux = 32'd0;
            CSR_NUM_BURSTS:  rd_mux = cfg_bursts;
            CSR_SAMPLES:     rd_mux = cfg_samples;
            CSR_GAP:         rd_mux = cfg_gap;
            CSR_BURSTS_DONE: rd_mux = bursts_done;
            default:         rd_mux = CSR_UNMAPPED;
        endcase
    end

    always_ff @(posedge csi_clk_clk) begin
        if (rsi_reset_reset) begin
            scratch           <= 32'd0;
            cfg_bursts        <= 32'd0;
            cfg_samples       <= 32'd0;
            cfg_gap           <= 32'd0;
            avs_ctrl_readdata <= 32'd0;
        end else begin
            if (avs_ctrl_read) avs_ctrl_readdata <= rd_mux;
            if (avs_ctrl_write) begin
                case (avs_ctrl_address)
                    CSR_SCRATCH:    scratch     <= avs_ctrl_writedata;
                    CSR_NUM_BURSTS: cfg_bursts  <= avs_ctrl_writedata;
                    CSR_SAMPLES:    cfg_samples <= avs_ctrl_writedata;
                    CSR_GAP:        cfg_gap     <= avs_ctrl_writedata;
                    default: ;
                endcase
            end
        end
    end

    // Master strobes are single-cycle pulses, never both high; address and
    // writedata are valid while the strobe is high, the slave has no waitrequest.
    always_ff @(posedge csi_clk_clk) begin
        if (rsi_reset_reset) begin
            state             <= S_IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
            ins_irq_irq       <= 1'b0;
            abort_pend        <= 1'b0;
            bursts_done       <= 32'd0;
            cnt               <= 32'd0;
            bursts_shadow     <= 32'd0;
            samples_shadow    <= 32'd0;
            gap_shadow        <= 32'd0;
            avm_gen_read      <= 1'b0;
            avm_gen_write     <= 1'b0;
            avm_gen_address   <= 4'd0;
            avm_gen_writedata <= 32'd0;
        end else begin
            avm_gen_read  <= 1'b0;
            avm_gen_write <= 1'b0;
            // Clears come first so that FSM sets later in this block win.
            if (status_clr) begin
                if (avs_ctrl_writedata[1]) done <= 1'b0;
                if (avs_ctrl_writedata[2]) err  <= 1'b0;
                if (avs_ctrl_writedata[1] || avs_ctrl_writedata[2]) ins_irq_irq <= 1'b0;
            end
            if (abort_req && state != S_IDLE) abort_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        bursts_shadow  <= cfg_bursts;
                        samples_shadow <= cfg_samples;
                        gap_shadow     <= cfg_gap;
                        bursts_done    <= 32'd0;
                        done           <= 1'b0;
                        if (cfg_samples == 32'd0) begin
                            err         <= 1'b1;
                            ins_irq_irq <= 1'b1;
                        end else if (cfg_bursts == 32'd0) begin
                            done        <= 1'b1;
                            ins_irq_irq <= 1'b1;
                        end else begin
                            busy              <= 1'b1;
                            state             <= S_WR_SAMP;
                            avm_gen_write     <= 1'b1;
                            avm_gen_address   <= GEN_ADDR_SAMPLES;
                            avm_gen_writedata <= cfg_samples;
                        end
                    end
                end
                S_WR_SAMP: begin
                    avm_gen_write     <= 1'b1;
                    avm_gen_address   <= GEN_ADDR_START;
                    avm_gen_writedata <= 32'd1;
                    state             <= S_WR_START;
                end
                S_WR_START: begin
                    cnt   <= 32'(SETTLE_CYC);
                    state <= S_SETTLE;
                end
                S_SETTLE, S_POLL_WAIT: begin
                    if (cnt == 32'd0) begin
                        avm_gen_read    <= 1'b1;
                        avm_gen_address <= GEN_ADDR_STATE;
                        state           <= S_POLL_RD;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                S_POLL_RD: state <= S_POLL_CHK;
                S_POLL_CHK: begin
                    if (avm_gen_readdata[0]) begin
                        cnt   <= 32'(POLL_INTERVAL);
                        state <= S_POLL_WAIT;
                    end else begin
                        bursts_done <= bursts_done + 32'd1;
                        if ((bursts_done + 32'd1 == bursts_shadow) || abort_pend || abort_req) begin
                            state <= S_FINISH;
                        end else begin
                            cnt   <= gap_shadow;
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (abort_pend || abort_req) begin
                        state <= S_FINISH;
                    end else if (cnt == 32'd0) begin
                        avm_gen_write     <= 1'b1;
                        avm_gen_address   <= GEN_ADDR_SAMPLES;
                        avm_gen_writedata <= samples_shadow;
                        state             <= S_WR_SAMP;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                S_FINISH: begin
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    ins_irq_irq <= 1'b1;
                    abort_pend  <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_st_gen_sequencer.sv
// Bench for the burst sequencer, paired with a small behavioural pattern generator.
module tb_avalon_st_gen_sequencer;
    import avalon_st_gen_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  avs_ctrl_address;
    logic        avs_ctrl_read, avs_ctrl_write;
    logic [31:0] avs_ctrl_readdata, avs_ctrl_writedata;
    logic [3:0]  avm_gen_address;
    logic        avm_gen_read, avm_gen_write;
    logic [31:0] avm_gen_writedata, avm_gen_readdata;
    logic        ins_irq_irq;

    avalon_st_gen_sequencer dut (
        .csi_clk_clk        (clk),
        .rsi_reset_reset    (rst),
        .avs_ctrl_address   (avs_ctrl_address),
        .avs_ctrl_read      (avs_ctrl_read),
        .avs_ctrl_write     (avs_ctrl_write),
        .avs_ctrl_readdata  (avs_ctrl_readdata),
        .avs_ctrl_writedata (avs_ctrl_writedata),
        .avm_gen_address    (avm_gen_address),
        .avm_gen_read       (avm_gen_read),
        .avm_gen_write      (avm_gen_write),
        .avm_gen_writedata  (avm_gen_writedata),
        .avm_gen_readdata   (avm_gen_readdata),
        .ins_irq_irq        (ins_irq_irq)
    );

    // generator model and master-side monitor
    logic        gen_busy = 1'b0;
    logic [31:0] gen_samples = 32'd0, gen_remaining = 32'd0, gen_rdata = 32'd0;
    logic        gen_ready = 1'b1, rand_ready = 1'b0, meas_clr = 1'b0;
    int          cyc = 0, beats_total = 0, start_writes = 0, overlap_cnt = 0;
    int          last_beat_cyc = -1, min_gap = 1 << 30, obs_cnt = 0;
    logic [35:0] obs_wr [0:127];

    assign avm_gen_readdata = gen_rdata;

    always @(negedge clk) gen_ready <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (avm_gen_read && avm_gen_write) overlap_cnt <= overlap_cnt + 1;
        if (avm_gen_write && obs_cnt < 128) begin
            obs_wr[obs_cnt] <= {avm_gen_address, avm_gen_writedata};
            obs_cnt <= obs_cnt + 1;
        end
        if (rst) begin
            gen_busy  <= 1'b0;
            gen_rdata <= 32'd0;
        end else begin
            if (gen_busy && gen_ready) begin
                beats_total <= beats_total + 1;
                if (last_beat_cyc >= 0 && cyc - last_beat_cyc - 1 > 0 && cyc - last_beat_cyc - 1 < min_gap)
                    min_gap <= cyc - last_beat_cyc - 1;
                last_beat_cyc <= cyc;
                gen_remaining <= gen_remaining - 32'd1;
                if (gen_remaining == 32'd1) gen_busy <= 1'b0;
            end
            if (avm_gen_write && avm_gen_address == GEN_ADDR_SAMPLES) gen_samples <= avm_gen_writedata;
            if (avm_gen_write && avm_gen_address == GEN_ADDR_START && avm_gen_writedata[0]) begin
                gen_busy      <= 1'b1;
                gen_remaining <= gen_samples;
                start_writes  <= start_writes + 1;
            end
            if (avm_gen_read) gen_rdata <= (avm_gen_address == GEN_ADDR_STATE) ? {31'd0, gen_busy} : 32'd0;
        end
        if (meas_clr) begin
            last_beat_cyc <= -1;
            min_gap       <= 1 << 30;
        end
    end

    // scoreboard
    int          total = 0, bad = 0, obs_rd = 0;
    logic [31:0] exp_q[$];
    logic [35:0] exp_wr_q[$];

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_ctrl_address = a; avs_ctrl_writedata = d; avs_ctrl_write = 1'b1;
        @(negedge clk);
        avs_ctrl_write = 1'b0;
    endtask

    task automatic host_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        logic [31:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        avs_ctrl_address = a; avs_ctrl_read = 1'b1;
        @(negedge clk);
        avs_ctrl_read = 1'b0;
        e = exp_q.pop_front();
        check(name, {4'd0, avs_ctrl_readdata}, {4'd0, e});
    endtask

    task automatic expect_bursts(input int n, input logic [31:0] samples);
        for (int i = 0; i < n; i++) begin
            exp_wr_q.push_back({GEN_ADDR_SAMPLES, samples});
            exp_wr_q.push_back({GEN_ADDR_START, 32'd1});
        end
    endtask

    task automatic compare_writes(input string name);
        int n_obs;
        logic [35:0] e;
        n_obs = obs_cnt - obs_rd;
        check({name, " write count"}, 36'(n_obs), 36'(exp_wr_q.size()));
        while (obs_rd < obs_cnt && exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front();
            check({name, " write"}, obs_wr[obs_rd], e);
            obs_rd++;
        end
        obs_rd = obs_cnt;
        exp_wr_q.delete();
    endtask

    task automatic wait_irq(input int budget, input string name);
        int n;
        n = 0;
        while (!ins_irq_irq && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {35'd0, ins_irq_irq}, 36'd1);
    endtask

    task automatic configure(input logic [31:0] b, input logic [31:0] s, input logic [31:0] g);
        host_write(CSR_NUM_BURSTS, b);
        host_write(CSR_SAMPLES, s);
        host_write(CSR_GAP, g);
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        do_write;
        logic [31:0] exp;
    } csr_vec_t;

    csr_vec_t vecs[20];

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        int base_beats, base_starts, n;

        vecs[0]  = '{CSR_ID,          32'd0,         1'b0, SEQ_ID};
        vecs[1]  = '{CSR_VERSION,     32'd0,         1'b0, 32'h00000100};
        vecs[2]  = '{CSR_ZERO,        32'd0,         1'b0, 32'd0};
        vecs[3]  = '{CSR_SCRATCH,     32'd0,         1'b0, 32'd0};
        vecs[4]  = '{CSR_STATUS,      32'd0,         1'b0, 32'd0};
        vecs[5]  = '{CSR_CTRL,        32'd0,         1'b0, 32'd0};
        vecs[6]  = '{CSR_NUM_BURSTS,  32'd0,         1'b0, 32'd0};
        vecs[7]  = '{CSR_SAMPLES,     32'd0,         1'b0, 32'd0};
        vecs[8]  = '{CSR_GAP,         32'd0,         1'b0, 32'd0};
        vecs[9]  = '{CSR_BURSTS_DONE, 32'd0,         1'b0, 32'd0};
        vecs[10] = '{4'd10,           32'd0,         1'b0, 32'hdeadbeef};
        vecs[11] = '{4'd15,           32'd0,         1'b0, 32'hdeadbeef};
        vecs[12] = '{CSR_SCRATCH,     32'ha5a55a5a,  1'b1, 32'ha5a55a5a};
        vecs[13] = '{CSR_NUM_BURSTS,  32'd7,         1'b1, 32'd7};
        vecs[14] = '{CSR_SAMPLES,     32'd100,       1'b1, 32'd100};
        vecs[15] = '{CSR_GAP,         32'hfffffff0,  1'b1, 32'hfffffff0};
        vecs[16] = '{CSR_BURSTS_DONE, 32'h1234,      1'b1, 32'd0};
        vecs[17] = '{CSR_VERSION,     32'd0,         1'b1, 32'h00000100};
        vecs[18] = '{CSR_ZERO,        32'hffffffff,  1'b1, 32'd0};
        vecs[19] = '{4'd12,           32'd1,         1'b1, 32'hdeadbeef};

        rst = 1'b1;
        avs_ctrl_address = 4'd0; avs_ctrl_read = 1'b0; avs_ctrl_write = 1'b0;
        avs_ctrl_writedata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset state and CSR map
        check("rst gen_read",  {35'd0, avm_gen_read}, 36'd0);
        check("rst gen_write", {35'd0, avm_gen_write}, 36'd0);
        check("rst gen_addr",  {32'd0, avm_gen_address}, 36'd0);
        check("rst gen_wdata", {4'd0, avm_gen_writedata}, 36'd0);
        check("rst irq",       {35'd0, ins_irq_irq}, 36'd0);
        check("rst readdata",  {4'd0, avs_ctrl_readdata}, 36'd0);
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].do_write) host_write(vecs[i].addr, vecs[i].wdata);
            host_read(vecs[i].addr, vecs[i].exp, $sformatf("csr vec %0d", i));
        end

        // 2: three bursts of 100 with a gap of 10
        configure(32'd3, 32'd100, 32'd10);
        expect_bursts(3, 32'd100);
        base_beats = beats_total; base_starts = start_writes;
        @(negedge clk); meas_clr = 1'b1; @(negedge clk); meas_clr = 1'b0;
        host_write(CSR_CTRL, 32'd1);
        wait_irq(5000, "t2 irq");
        check("t2 beats",  36'(beats_total - base_beats), 36'd300);
        check("t2 starts", 36'(start_writes - base_starts), 36'd3);
        check("t2 gap",    36'((min_gap >= 10 && min_gap < (1 << 30)) ? 1 : 0), 36'd1);
        host_read(CSR_BURSTS_DONE, 32'd3, "t2 bursts_done");
        host_read(CSR_STATUS, 32'h2, "t2 status");
        compare_writes("t2");
        host_write(CSR_STATUS, 32'h2);
        host_read(CSR_STATUS, 32'h0, "t2 status clr");
        check("t2 irq clr", {35'd0, ins_irq_irq}, 36'd0);

        // 3: zero samples -> error, zero bursts -> immediate done
        configure(32'd1, 32'd0, 32'd0);
        host_write(CSR_CTRL, 32'd1);
        repeat (4) @(negedge clk);
        host_read(CSR_STATUS, 32'h4, "t3 err status");
        check("t3 err irq", {35'd0, ins_irq_irq}, 36'd1);
        host_write(CSR_STATUS, 32'h6);
        host_read(CSR_STATUS, 32'h0, "t3 err clr");
        check("t3 irq clr", {35'd0, ins_irq_irq}, 36'd0);
        configure(32'd0, 32'd5, 32'd0);
        host_write(CSR_CTRL, 32'd1);
        repeat (4) @(negedge clk);
        host_read(CSR_STATUS, 32'h2, "t3 zero bursts status");
        check("t3 zero bursts irq", {35'd0, ins_irq_irq}, 36'd1);
        compare_writes("t3");
        host_write(CSR_STATUS, 32'h6);

        // 4: abort halfway through the first of five bursts
        configure(32'd5, 32'd1000, 32'd3);
        expect_bursts(1, 32'd1000);
        base_beats = beats_total;
        host_write(CSR_CTRL, 32'd1);
        n = 0;
        while (beats_total - base_beats < 500 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("t4 reach beat 500", 36'((beats_total - base_beats >= 500) ? 1 : 0), 36'd1);
        host_write(CSR_CTRL, 32'd2);
        wait_irq(5000, "t4 irq");
        check("t4 beats", 36'(beats_total - base_beats), 36'd1000);
        host_read(CSR_BURSTS_DONE, 32'd1, "t4 bursts_done");
        host_read(CSR_STATUS, 32'h2, "t4 status");
        compare_writes("t4");
        host_write(CSR_STATUS, 32'h2);

        // 5: start while busy, config change while busy, ready toggling
        configure(32'd2, 32'd50, 32'd4);
        expect_bursts(2, 32'd50);
        base_beats = beats_total;
        rand_ready = 1'b1;
        host_write(CSR_CTRL, 32'd1);
        n = 0;
        while (beats_total - base_beats < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        host_write(CSR_SAMPLES, 32'd7);
        host_write(CSR_CTRL, 32'd1);
        wait_irq(5000, "t5 irq");
        rand_ready = 1'b0;
        check("t5 beats", 36'(beats_total - base_beats), 36'd100);
        host_read(CSR_BURSTS_DONE, 32'd2, "t5 bursts_done");
        host_read(CSR_STATUS, 32'h2, "t5 status");
        host_write(CSR_CTRL, 32'd3);
        repeat (40) @(negedge clk);
        host_read(CSR_STATUS, 32'h2, "t5 start+abort status");
        host_read(CSR_BURSTS_DONE, 32'd2, "t5 start+abort bursts_done");
        check("t5 start+abort irq", {35'd0, ins_irq_irq}, 36'd1);
        compare_writes("t5");
        host_write(CSR_STATUS, 32'h2);

        // 6: reset while polling
        configure(32'd2, 32'd100, 32'd0);
        expect_bursts(1, 32'd100);
        host_write(CSR_CTRL, 32'd1);
        n = 0;
        while (dut.state != S_POLL_WAIT && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t6 reach poll_wait", {32'd0, dut.state}, {32'd0, S_POLL_WAIT});
        rst = 1'b1;
        @(negedge clk);
        check("t6 state", {32'd0, dut.state}, {32'd0, S_IDLE});
        check("t6 gen_read",  {35'd0, avm_gen_read}, 36'd0);
        check("t6 gen_write", {35'd0, avm_gen_write}, 36'd0);
        rst = 1'b0;
        host_read(CSR_STATUS, 32'h0, "t6 status");
        host_read(CSR_BURSTS_DONE, 32'd0, "t6 bursts_done");
        check("t6 irq", {35'd0, ins_irq_irq}, 36'd0);
        compare_writes("t6");

        check("strobe overlap", 36'(overlap_cnt), 36'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
